// File: rtl/id_ex_ctrl_stage_if.sv
// id_ex_ctrl_stage_if: bundle of decode-side control fields, hazard-unit
// controls and registered execute-side copies for the ID->EX control stage.
// Optional configuration macro: PERF_CNT_EN (adds bubble/taken counters).
// master: decode/hazard side that drives the _d fields and stall/flush.
// slave : the pipeline stage itself.
interface id_ex_ctrl_stage_if #(
  parameter int REG_AW = 5
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  // hazard-unit controls and EX-side ALU flag
  logic              stall_e;
  logic              flush_e;
  logic              zero_e;

  // decoded control for the instruction currently in ID
  logic              valid_d;
  logic              reg_write_d;
  logic [1:0]        result_src_d;
  logic              mem_write_d;
  logic              branch_d;
  logic              jump_d;
  logic              branch_neg_d;
  logic [2:0]        alu_ctrl_d;
  logic              alu_src_d;
  logic [REG_AW-1:0] rd_d;

  // registered control for the instruction currently in EX
  logic              valid_e;
  logic              reg_write_e;
  logic [1:0]        result_src_e;
  logic              mem_write_e;
  logic              branch_e;
  logic              jump_e;
  logic              branch_neg_e;
  logic [2:0]        alu_ctrl_e;
  logic              alu_src_e;
  logic [REG_AW-1:0] rd_e;

  // resolved control-flow and hazard information
  logic              pc_src_e;
  logic              load_in_ex_e;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0]  bubble_cnt_e;
  logic [CNT_W-1:0]  taken_cnt_e;
`endif

  modport master (
    output stall_e, flush_e, zero_e,
    output valid_d, reg_write_d, result_src_d, mem_write_d, branch_d,
    output jump_d, branch_neg_d, alu_ctrl_d, alu_src_d, rd_d,
    input
`ifdef PERF_CNT_EN
    bubble_cnt_e, taken_cnt_e,
`endif
    valid_e, reg_write_e, result_src_e, mem_write_e, branch_e,
    jump_e, branch_neg_e, alu_ctrl_e, alu_src_e, rd_e,
    pc_src_e, load_in_ex_e
  );

  modport slave (
    input  stall_e, flush_e, zero_e,
    input  valid_d, reg_write_d, result_src_d, mem_write_d, branch_d,
    input  jump_d, branch_neg_d, alu_ctrl_d, alu_src_d, rd_d,
    output
`ifdef PERF_CNT_EN
    bubble_cnt_e, taken_cnt_e,
`endif
    valid_e, reg_write_e, result_src_e, mem_write_e, branch_e,
    jump_e, branch_neg_e, alu_ctrl_e, alu_src_e, rd_e,
    pc_src_e, load_in_ex_e
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: ID->EX pipeline register for decoded control plus rd.
// Inserts bubbles on flush, holds on stall, resolves branch/jump in EX and
// exports load-in-EX / rd_e for the hazard unit.
// Optional configuration macro: PERF_CNT_EN (saturating bubble and
// taken-branch counters, width CNT_W).
module id_ex_ctrl_stage #(
  parameter int REG_AW = 5
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_ctrl_stage_if.slave bus
);

  // One packed record keeps the bubble/hold/load cases uniform: a bubble is
  // simply the all-zero record.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              branch_neg;
    logic [2:0]        alu_ctrl;
    logic              alu_src;
    logic [REG_AW-1:0] rd;
  } ctrl_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;

  ctrl_t w_load;
  ctrl_t r_ctrl;
  logic  w_rd_is_x0;
  logic  w_cond_true;
  logic  w_pc_src;
  logic  w_load_in_ex;

  assign w_rd_is_x0 = (bus.rd_d == '0);

  // Qualify decode fields: invalid slots become bubbles, x0 is never written
  always_comb begin
    w_load = '0;
    if (bus.valid_d) begin
      w_load.valid      = 1'b1;
      w_load.reg_write  = bus.reg_write_d;
      w_load.result_src = bus.result_src_d;
      w_load.mem_write  = bus.mem_write_d;
      w_load.branch     = bus.branch_d;
      w_load.jump       = bus.jump_d;
      w_load.branch_neg = bus.branch_neg_d;
      w_load.alu_ctrl   = bus.alu_ctrl_d;
      w_load.alu_src    = bus.alu_src_d;
      w_load.rd         = bus.rd_d;
      // A write-back to x0 is dropped entirely, so the EX copy must not look
      // like a load either (keeps load-use stalls from firing needlessly).
      if (w_rd_is_x0) begin
        w_load.reg_write  = 1'b0;
        w_load.result_src = RES_ALU;
      end
    end
  end

  // EX register update: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (bus.flush_e) begin
      r_ctrl <= '0;
    end else if (!bus.stall_e) begin
      r_ctrl <= w_load;
    end
  end

  // Branch condition: zero flag optionally inverted (beq vs bne)
  assign w_cond_true  = bus.zero_e ^ r_ctrl.branch_neg;

  // Bubbles have valid=0, so neither signal can assert for them.
  assign w_pc_src     = r_ctrl.valid & (r_ctrl.jump | (r_ctrl.branch & w_cond_true));
  assign w_load_in_ex = r_ctrl.valid & (r_ctrl.result_src == RES_MEM);

  assign bus.valid_e      = r_ctrl.valid;
  assign bus.reg_write_e  = r_ctrl.reg_write;
  assign bus.result_src_e = r_ctrl.result_src;
  assign bus.mem_write_e  = r_ctrl.mem_write;
  assign bus.branch_e     = r_ctrl.branch;
  assign bus.jump_e       = r_ctrl.jump;
  assign bus.branch_neg_e = r_ctrl.branch_neg;
  assign bus.alu_ctrl_e   = r_ctrl.alu_ctrl;
  assign bus.alu_src_e    = r_ctrl.alu_src;
  assign bus.rd_e         = r_ctrl.rd;
  assign bus.pc_src_e     = w_pc_src;
  assign bus.load_in_ex_e = w_load_in_ex;

`ifdef PERF_CNT_EN
  // Counter 0 counts bubble cycles, counter 1 counts taken, unstalled
  // redirects. Both stop at all-ones rather than wrapping.
  logic [1:0] w_cnt_inc;

  assign w_cnt_inc[0] = ~r_ctrl.valid;
  assign w_cnt_inc[1] = w_pc_src & ~bus.stall_e;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Saturating event counter, cleared by reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_cnt_inc[gi] && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.bubble_cnt_e = g_cnt[0].r_cnt;
  assign bus.taken_cnt_e  = g_cnt[1].r_cnt;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage: directed scenarios followed by randomized stimulus,
// checked against a behavioural model of the EX-stage contents.
// Honours PERF_CNT_EN (counter checks are compiled in only when defined).
module tb_id_ex_ctrl_stage;
  localparam int REG_AW = 5;
`ifdef PERF_CNT_EN
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   model_known = 1'b0;

  id_ex_ctrl_stage_if #(
    .REG_AW(REG_AW)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  id_ex_ctrl_stage #(
    .REG_AW(REG_AW)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected content of the EX slot
  typedef struct {
    bit       valid;
    bit       reg_write;
    bit [1:0] result_src;
    bit       mem_write;
    bit       branch;
    bit       jump;
    bit       bneg;
    bit [2:0] alu_ctrl;
    bit       alu_src;
    bit [4:0] rd;
  } ex_t;

  ex_t exp_ex;
  int  exp_bub = 0;
  int  exp_tak = 0;

  function automatic bit exp_pc_src();
    if (!exp_ex.valid) return 1'b0;
    if (exp_ex.jump) return 1'b1;
    return exp_ex.branch && (bus.zero_e != exp_ex.bneg);
  endfunction

  function automatic bit exp_load();
    return exp_ex.valid && (exp_ex.result_src == 2'b01);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_d(input bit v, input bit rw, input bit [1:0] rs, input bit mw,
                       input bit br, input bit j, input bit bn, input bit [2:0] alu,
                       input bit asrc, input bit [4:0] rd);
    bus.valid_d      = v;
    bus.reg_write_d  = rw;
    bus.result_src_d = rs;
    bus.mem_write_d  = mw;
    bus.branch_d     = br;
    bus.jump_d       = j;
    bus.branch_neg_d = bn;
    bus.alu_ctrl_d   = alu;
    bus.alu_src_d    = asrc;
    bus.rd_d         = rd;
  endtask

  // What the EX slot should hold after a clock edge, from the stage's rules
  task automatic model_edge();
    ex_t nxt;
    nxt = exp_ex;
    if (!rst_n || bus.flush_e) begin
      nxt = '{default: 0};
    end else if (!bus.stall_e) begin
      if (!bus.valid_d) begin
        nxt = '{default: 0};
      end else begin
        nxt.valid      = 1'b1;
        nxt.reg_write  = bus.reg_write_d && (bus.rd_d != 0);
        nxt.result_src = (bus.rd_d == 0) ? 2'b00 : bus.result_src_d;
        nxt.mem_write  = bus.mem_write_d;
        nxt.branch     = bus.branch_d;
        nxt.jump       = bus.jump_d;
        nxt.bneg       = bus.branch_neg_d;
        nxt.alu_ctrl   = bus.alu_ctrl_d;
        nxt.alu_src    = bus.alu_src_d;
        nxt.rd         = bus.rd_d;
      end
    end
    exp_ex = nxt;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_valid"},  32'(bus.valid_e),      32'(exp_ex.valid));
    check({pfx, "_rw"},     32'(bus.reg_write_e),  32'(exp_ex.reg_write));
    check({pfx, "_rs"},     32'(bus.result_src_e), 32'(exp_ex.result_src));
    check({pfx, "_mw"},     32'(bus.mem_write_e),  32'(exp_ex.mem_write));
    check({pfx, "_br"},     32'(bus.branch_e),     32'(exp_ex.branch));
    check({pfx, "_jmp"},    32'(bus.jump_e),       32'(exp_ex.jump));
    check({pfx, "_bneg"},   32'(bus.branch_neg_e), 32'(exp_ex.bneg));
    check({pfx, "_alu"},    32'(bus.alu_ctrl_e),   32'(exp_ex.alu_ctrl));
    check({pfx, "_asrc"},   32'(bus.alu_src_e),    32'(exp_ex.alu_src));
    check({pfx, "_rd"},     32'(bus.rd_e),         32'(exp_ex.rd));
    check({pfx, "_pcsrc"},  32'(bus.pc_src_e),     32'(exp_pc_src()));
    check({pfx, "_ldex"},   32'(bus.load_in_ex_e), 32'(exp_load()));
`ifdef PERF_CNT_EN
    check({pfx, "_bubcnt"}, 32'(bus.bubble_cnt_e), 32'(exp_bub));
    check({pfx, "_takcnt"}, 32'(bus.taken_cnt_e),  32'(exp_tak));
`endif
  endtask

  // One clock: check combinational outputs before the edge, advance the
  // model at the edge, check everything just after it.
  task automatic cycle(input string tag);
    bit taken_now;
    #1;
    taken_now = exp_pc_src();
    if (model_known) begin
      check({tag, "_pre_pcsrc"}, 32'(bus.pc_src_e),     32'(taken_now));
      check({tag, "_pre_ldex"},  32'(bus.load_in_ex_e), 32'(exp_load()));
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_bub = 0;
      exp_tak = 0;
    end else if (model_known) begin
`ifdef PERF_CNT_EN
      if (!exp_ex.valid && exp_bub < CNT_MAX) exp_bub++;
      if (taken_now && !bus.stall_e && exp_tak < CNT_MAX) exp_tak++;
`endif
    end
    model_edge();
    if (!rst_n) model_known = 1'b1;
    #1;
    if (model_known) check_all(tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.stall_e = 1'b1;
    bus.flush_e = 1'b1;
    bus.zero_e  = 1'b1;
    exp_ex      = '{default: 0};
    set_d(1, 1, 2'b11, 1, 1, 1, 1, 3'b111, 1, 5'h1f);
    @(negedge clk);

    // Reset overrides stall/flush with all decode fields set
    cycle("reset");
    check("reset_valid", 32'(bus.valid_e), 32'd0);
    check("reset_rd",    32'(bus.rd_e),    32'd0);
    check("reset_pcsrc", 32'(bus.pc_src_e), 32'd0);
    rst_n = 1'b1;
    bus.stall_e = 1'b0;
    bus.flush_e = 1'b0;

    // Pass-through: add x5
    set_d(1, 1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 5'd5);
    cycle("add_x5");
    check("add_valid", 32'(bus.valid_e),     32'd1);
    check("add_rw",    32'(bus.reg_write_e), 32'd1);
    check("add_rd",    32'(bus.rd_e),        32'd5);

    // Stall two cycles with different decode contents: EX holds
    bus.stall_e = 1'b1;
    set_d(1, 1, 2'b01, 1, 0, 0, 0, 3'b010, 1, 5'd9);
    cycle("stall1");
    set_d(0, 0, 2'b10, 0, 1, 1, 0, 3'b101, 0, 5'd3);
    cycle("stall2");
    check("stall_rd", 32'(bus.rd_e), 32'd5);
    bus.stall_e = 1'b0;

    // beq in EX
    set_d(1, 0, 2'b00, 0, 1, 0, 0, 3'b001, 0, 5'd0);
    cycle("beq");
    bus.zero_e = 1'b1; #1;
    check("beq_z1", 32'(bus.pc_src_e), 32'd1);
    bus.zero_e = 1'b0; #1;
    check("beq_z0", 32'(bus.pc_src_e), 32'd0);

    // bne in EX
    set_d(1, 0, 2'b00, 0, 1, 0, 1, 3'b001, 0, 5'd0);
    cycle("bne");
    bus.zero_e = 1'b0; #1;
    check("bne_z0", 32'(bus.pc_src_e), 32'd1);

    // jal in EX: taken regardless of zero
    set_d(1, 1, 2'b10, 0, 0, 1, 0, 3'b000, 0, 5'd1);
    cycle("jal");
    bus.zero_e = 1'b0; #1;
    check("jal_z0", 32'(bus.pc_src_e), 32'd1);
    bus.zero_e = 1'b1; #1;
    check("jal_z1", 32'(bus.pc_src_e), 32'd1);

    // Flush wins over stall
    bus.flush_e = 1'b1;
    bus.stall_e = 1'b1;
    cycle("flush");
    check("flush_valid", 32'(bus.valid_e),  32'd0);
    check("flush_pcsrc", 32'(bus.pc_src_e), 32'd0);
    check("flush_rd",    32'(bus.rd_e),     32'd0);
    bus.flush_e = 1'b0;
    bus.stall_e = 1'b0;

    // lw x7 and lw x0
    set_d(1, 1, 2'b01, 0, 0, 0, 0, 3'b000, 1, 5'd7);
    cycle("lw_x7");
    check("lw7_ldex", 32'(bus.load_in_ex_e), 32'd1);
    set_d(1, 1, 2'b01, 0, 0, 0, 0, 3'b000, 1, 5'd0);
    cycle("lw_x0");
    check("lw0_rw",   32'(bus.reg_write_e),  32'd0);
    check("lw0_ldex", 32'(bus.load_in_ex_e), 32'd0);

`ifdef PERF_CNT_EN
    // 3 bubbles then 2 taken unstalled branches
    rst_n = 1'b0;
    cycle("perf_rst");
    rst_n = 1'b1;
    bus.zero_e = 1'b1;
    set_d(0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 5'd0);
    cycle("perf_b1");
    cycle("perf_b2");
    set_d(1, 0, 2'b00, 0, 1, 0, 0, 3'b001, 0, 5'd0);
    cycle("perf_b3");
    cycle("perf_t1");
    set_d(1, 1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 5'd4);
    cycle("perf_t2");
    check("perf_bub3", 32'(bus.bubble_cnt_e), 32'd3);
    check("perf_tak2", 32'(bus.taken_cnt_e),  32'd2);
    // 5 bubbles saturate a 2-bit counter at 3
    rst_n = 1'b0;
    cycle("sat_rst");
    rst_n = 1'b1;
    set_d(0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 5'd0);
    for (int i = 0; i < 5; i++) cycle("sat_bub");
    check("sat_bub", 32'(bus.bubble_cnt_e), 32'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 40) != 0);
      bus.flush_e = ($urandom_range(0, 9) == 0);
      bus.stall_e = ($urandom_range(0, 3) == 0);
      bus.zero_e  = 1'($urandom);
      set_d(($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), 3'($urandom),
            1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
